// File: rtl/mux4_cross1_pkg.sv
// Shared definitions for the mux4_cross1 steering block.
// Holds the select-code constants used to decode {s1, s0}.
package mux4_cross1_pkg;

  localparam int unsigned SEL_W = 2;

  // Select codes: {s1, s0}
  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D = 2'b11;

endpackage : mux4_cross1_pkg

// File: rtl/mux4_cross1.sv
// mux4_cross1: 4-to-1 multiplexer with a combinational output and
// a registered copy of the selected data and select code.
//
// Ports:
//   a, b, c, d : WIDTH-bit data sources 0..3
//   s0, s1     : select LSB / MSB, code = {s1, s0}
//   y          : combinational selected data (not affected by rst)
//   y_q        : selected data registered on rising clk
//   sel_q      : {s1, s0} registered on rising clk
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset of y_q / sel_q
module mux4_cross1
  import mux4_cross1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [SEL_W-1:0] sel_q,
  input  logic             clk,
  input  logic             rst
);

  logic [SEL_W-1:0] sel_c;

  assign sel_c = {s1, s0};

  // Combinational source select; reset never gates this path.
  always_comb begin
    y = a;
    case (sel_c)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = a;
    endcase
  end

  // Output register; reset wins over the sampled data.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= SEL_A;
    end else begin
      y_q   <= y;
      sel_q <= sel_c;
    end
  end

endmodule : mux4_cross1

// File: tb/tb_mux4_cross1.sv
// Directed testbench for mux4_cross1 at WIDTH=1 and WIDTH=8.
module tb_mux4_cross1;

  logic       clk;
  logic       rst;
  logic       s0;
  logic       s1;

  logic       a1, b1, c1, d1;
  logic       y1, y_q1;
  logic [1:0] sel_q1;

  logic [7:0] a8, b8, c8, d8;
  logic [7:0] y8, y_q8;
  logic [1:0] sel_q8;

  int tests;
  int fails;

  mux4_cross1 u_dut1 (
    .a(a1), .b(b1), .c(c1), .d(d1),
    .s0(s0), .s1(s1),
    .y(y1), .y_q(y_q1), .sel_q(sel_q1),
    .clk(clk), .rst(rst)
  );

  mux4_cross1 #(.WIDTH(8)) u_dut8 (
    .a(a8), .b(b8), .c(c8), .d(d8),
    .s0(s0), .s1(s1),
    .y(y8), .y_q(y_q8), .sel_q(sel_q8),
    .clk(clk), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the WIDTH=1 data and the shared select, then settle.
  task automatic drive1(input logic va, input logic vb, input logic vc,
                        input logic vd, input logic vs1, input logic vs0);
    a1 = va; b1 = vb; c1 = vc; d1 = vd;
    s1 = vs1; s0 = vs0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (y_q1 !== 1'b0) begin
      fails++; $display("FAIL reset_y_q1: got %b expected 0", y_q1);
    end
    tests++;
    if (sel_q1 !== 2'b00) begin
      fails++; $display("FAIL reset_sel_q1: got %b expected 00", sel_q1);
    end
    tests++;
    if (y_q8 !== 8'h00) begin
      fails++; $display("FAIL reset_y_q8: got %h expected 00", y_q8);
    end
    tests++;
    if (sel_q8 !== 2'b00) begin
      fails++; $display("FAIL reset_sel_q8: got %b expected 00", sel_q8);
    end
    rst = 1'b0;
  endtask

  task automatic test_sel00();
    drive1(1, 0, 0, 0, 0, 0);
    tests++;
    if (y1 !== 1'b1) begin
      fails++; $display("FAIL sel00_a1: got %b expected 1", y1);
    end
    drive1(0, 1, 1, 1, 0, 0);
    tests++;
    if (y1 !== 1'b0) begin
      fails++; $display("FAIL sel00_a0: got %b expected 0", y1);
    end
  endtask

  task automatic test_sel01();
    drive1(0, 1, 0, 0, 0, 1);
    tests++;
    if (y1 !== 1'b1) begin
      fails++; $display("FAIL sel01_b1: got %b expected 1", y1);
    end
    drive1(1, 0, 1, 1, 0, 1);
    tests++;
    if (y1 !== 1'b0) begin
      fails++; $display("FAIL sel01_b0: got %b expected 0", y1);
    end
  endtask

  task automatic test_sel10();
    drive1(0, 0, 1, 0, 1, 0);
    tests++;
    if (y1 !== 1'b1) begin
      fails++; $display("FAIL sel10_c1: got %b expected 1", y1);
    end
    drive1(1, 1, 0, 0, 1, 0);
    tests++;
    if (y1 !== 1'b0) begin
      fails++; $display("FAIL sel10_c0: got %b expected 0", y1);
    end
    drive1(0, 0, 0, 1, 1, 0);
    tests++;
    if (y1 !== 1'b0) begin
      fails++; $display("FAIL sel10_d_only: got %b expected 0", y1);
    end
  endtask

  task automatic test_sel11();
    drive1(1, 1, 1, 0, 1, 1);
    tests++;
    if (y1 !== 1'b0) begin
      fails++; $display("FAIL sel11_d0: got %b expected 0", y1);
    end
    drive1(1, 1, 1, 1, 1, 1);
    tests++;
    if (y1 !== 1'b1) begin
      fails++; $display("FAIL sel11_d1: got %b expected 1", y1);
    end
  endtask

  task automatic test_registered();
    rst = 1'b1;
    drive1(1, 1, 1, 1, 1, 1);
    @(posedge clk); #1;
    tests++;
    if (y_q1 !== 1'b0) begin
      fails++; $display("FAIL reg_rst_y_q: got %b expected 0", y_q1);
    end
    tests++;
    if (sel_q1 !== 2'b00) begin
      fails++; $display("FAIL reg_rst_sel_q: got %b expected 00", sel_q1);
    end
    rst = 1'b0;
    drive1(0, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    tests++;
    if (y_q1 !== 1'b1) begin
      fails++; $display("FAIL reg_y_q: got %b expected 1", y_q1);
    end
    tests++;
    if (sel_q1 !== 2'b10) begin
      fails++; $display("FAIL reg_sel_q: got %b expected 10", sel_q1);
    end
  endtask

  task automatic test_reset_priority();
    drive1(1, 0, 0, 0, 0, 1);
    drive1(0, 1, 0, 0, 0, 1);
    @(posedge clk); #1;
    tests++;
    if (y_q1 !== 1'b1) begin
      fails++; $display("FAIL prio_pre_y_q: got %b expected 1", y_q1);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (y1 !== 1'b1) begin
      fails++; $display("FAIL prio_y_during_rst: got %b expected 1", y1);
    end
    @(posedge clk); #1;
    tests++;
    if (y_q1 !== 1'b0) begin
      fails++; $display("FAIL prio_y_q: got %b expected 0", y_q1);
    end
    tests++;
    if (sel_q1 !== 2'b00) begin
      fails++; $display("FAIL prio_sel_q: got %b expected 00", sel_q1);
    end
    tests++;
    if (y1 !== 1'b1) begin
      fails++; $display("FAIL prio_y_after: got %b expected 1", y1);
    end
    rst = 1'b0;
  endtask

  task automatic test_width8();
    logic [7:0] exp_tab [4];
    logic [1:0] code;
    exp_tab = '{8'h11, 8'h22, 8'h44, 8'h88};
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h44; d8 = 8'h88;
    for (int i = 0; i < 4; i++) begin
      code = 2'(i);
      s1 = code[1];
      s0 = code[0];
      #1;
      tests++;
      if (y8 !== exp_tab[i]) begin
        fails++; $display("FAIL w8_y sel=%b: got %h expected %h", code, y8, exp_tab[i]);
      end
      @(posedge clk); #1;
      tests++;
      if (y_q8 !== exp_tab[i]) begin
        fails++; $display("FAIL w8_y_q sel=%b: got %h expected %h", code, y_q8, exp_tab[i]);
      end
      tests++;
      if (sel_q8 !== code) begin
        fails++; $display("FAIL w8_sel_q: got %b expected %b", sel_q8, code);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    s0 = 1'b0; s1 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; d8 = 8'h00;
    #2;
    test_reset();
    test_sel00();
    test_sel01();
    test_sel10();
    test_sel11();
    test_registered();
    test_reset_priority();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mux4_cross1
